// File: rtl/iter_alu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// iter_alu
//
// Purpose:
//   Handshaked ALU. Simple operations (add/sub/logic/shift/compare) finish in
//   one cycle. Multiply and divide run as an iterative shift-add /
//   restoring shift-subtract engine that retires one bit per cycle.
//   Results and flags are registered and held until the consumer takes them.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous, active-high; returns block to IDLE
//   in_valid   - request present on op/input_A/input_B
//   in_ready   - block is IDLE and can capture a request
//   op         - 4-bit operation code
//   input_A    - operand A (WIDTH bits)
//   input_B    - operand B (WIDTH bits)
//   out_valid  - result/flags/Zero_Flag valid
//   out_ready  - consumer accepts the result
//   result     - registered result (WIDTH bits)
//   flags      - registered {dz, illegal, N, V, C}
//   Zero_Flag  - registered (result == 0)
// -----------------------------------------------------------------------------
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             Zero_Flag
);

  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Captured request and iterative engine state
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    count_q;

  logic in_fire;
  logic iter_op;
  logic div_op;
  logic is_div_q;
  logic b_zero;

  // Single-cycle datapath
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_c;
  logic             sc_v;
  logic             sc_illegal;

  // Iterative datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] it_result;
  logic             it_dz;

  // Requests are only captured in IDLE; in BUSY/DONE in_valid is ignored.
  assign in_fire  = in_valid && (state == IDLE);
  assign iter_op  = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  assign div_op   = (op == OP_DIVU) || (op == OP_REMU);
  assign is_div_q = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign b_zero   = (b_q == '0);

  assign add_ext = {1'b0, input_A} + {1'b0, input_B};
  // Subtract as A + ~B + 1 so the carry out means "no borrow".
  assign sub_ext = {1'b0, input_A} + {1'b0, ~input_B} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt   = input_B[SHW-1:0];

  // State register: async reset drops any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: single-cycle ops go straight to DONE, multiply/divide
  // spend WIDTH cycles in BUSY, and DONE waits for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_fire) begin
          state_next = iter_op ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (count_q == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is also masked while reset
  // is held so nothing is advertised during reset.
  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == DONE);
  end

  // Single-cycle operations evaluated straight from the input operands so the
  // result can be registered on the transfer edge.
  always_comb begin
    sc_result  = '0;
    sc_c       = 1'b0;
    sc_v       = 1'b0;
    sc_illegal = 1'b0;
    case (op)
      OP_ADD: begin
        sc_result = add_ext[WIDTH-1:0];
        sc_c      = add_ext[WIDTH];
        sc_v      = (input_A[WIDTH-1] == input_B[WIDTH-1]) &&
                    (add_ext[WIDTH-1] != input_A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_ext[WIDTH-1:0];
        sc_c      = sub_ext[WIDTH];
        sc_v      = (input_A[WIDTH-1] != input_B[WIDTH-1]) &&
                    (sub_ext[WIDTH-1] != input_A[WIDTH-1]);
      end
      OP_AND:  sc_result = input_A & input_B;
      OP_OR:   sc_result = input_A | input_B;
      OP_XOR:  sc_result = input_A ^ input_B;
      OP_SLL:  sc_result = input_A << shamt;
      OP_SRL:  sc_result = input_A >> shamt;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(input_A) < $signed(input_B))};
      OP_SRA:  sc_result = $unsigned($signed(input_A) >>> shamt);
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (input_A < input_B)};
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: sc_result = '0;
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration of the multiply/divide engine.
  // Multiply: {hi,lo} starts as {0,B}; each step conditionally adds A into hi
  // and shifts the whole pair right, so after WIDTH steps {hi,lo} = A*B.
  // Divide: hi is the partial remainder, lo starts as the dividend and fills
  // with quotient bits from the right (restoring division).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    if (is_div_q) begin
      hi_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_next = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Pick the final iterative result from the post-step values, since the last
  // step and the result load happen on the same edge. Divide by zero is
  // forced to the architectural values regardless of what the engine produced.
  always_comb begin
    it_result = lo_next;
    it_dz     = 1'b0;
    case (op_q)
      OP_MULHU: it_result = hi_next;
      OP_DIVU: begin
        if (b_zero) begin
          it_result = '1;
          it_dz     = 1'b1;
        end else begin
          it_result = lo_next;
        end
      end
      OP_REMU: begin
        if (b_zero) begin
          it_result = a_q;
          it_dz     = 1'b1;
        end else begin
          it_result = hi_next;
        end
      end
      default: it_result = lo_next;
    endcase
  end

  // Datapath registers. Operands are copied at input transfer so later changes
  // on input_A/input_B cannot disturb an operation already in flight. The
  // output registers are only written on completion, so they stay stable for
  // the whole DONE period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      result    <= '0;
      flags     <= '0;
      Zero_Flag <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            op_q <= op;
            a_q  <= input_A;
            b_q  <= input_B;
            if (iter_op) begin
              count_q <= ITERS;
              hi_q    <= '0;
              lo_q    <= div_op ? input_A : input_B;
            end else begin
              result    <= sc_result;
              flags     <= {1'b0, sc_illegal, sc_result[WIDTH-1], sc_v, sc_c};
              Zero_Flag <= (sc_result == '0);
            end
          end
        end
        BUSY: begin
          hi_q    <= hi_next;
          lo_q    <= lo_next;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            result    <= it_result;
            flags     <= {it_dz, 1'b0, it_result[WIDTH-1], 2'b00};
            Zero_Flag <= (it_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_iter_alu
//
// Purpose:
//   Scoreboard bench for iter_alu (WIDTH = 32). A driver issues requests and
//   pushes the reference-model answer into a queue; an independent monitor
//   pops and compares whenever the DUT presents a result, and applies random
//   backpressure on out_ready.
// -----------------------------------------------------------------------------
module tb_iter_alu;

  localparam int W   = 32;
  localparam int SHW = 5;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic         zero_flag;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cycle      = 0;
  bit inflight   = 0;
  bit started    = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   flg;
    logic         zf;
    int           lat;
    int           t_xfer;
    int           hold;
  } exp_t;

  exp_t sb[$];

  iter_alu #(.WIDTH(W), .SHW(SHW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .input_A  (a),
    .input_B  (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags),
    .Zero_Flag(zero_flag)
  );

  // Free-running clock and cycle counter used for latency measurement
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: plain arithmetic on wide integers
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [4:0] f, output int lat);
    longint       sx, sy, s;
    longint       max_s, min_s;
    logic [63:0]  p;
    logic         c, v, dz, ill;
    int           sh;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    max_s = (longint'(1) << (W - 1)) - 1;
    min_s = -(longint'(1) << (W - 1));
    sh    = int'(y % 32'(W));
    c = 1'b0; v = 1'b0; dz = 1'b0; ill = 1'b0;
    lat = 1;
    r = '0;
    p = '0;
    case (o)
      4'd0: begin
        p = 64'(x) + 64'(y);
        r = p[W-1:0];
        c = p[W];
        s = sx + sy;
        v = (s > max_s) || (s < min_s);
      end
      4'd1: begin
        r = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s > max_s) || (s < min_s);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x << sh;
      4'd6: r = x >> sh;
      4'd7: r = {{(W-1){1'b0}}, (sx < sy)};
      4'd8: r = W'(sx >>> sh);
      4'd9: r = {{(W-1){1'b0}}, (x < y)};
      4'd10: begin p = 64'(x) * 64'(y); r = p[W-1:0];   lat = W + 1; end
      4'd11: begin p = 64'(x) * 64'(y); r = p[2*W-1:W]; lat = W + 1; end
      4'd12: begin dz = (y == 0); r = dz ? '1 : x / y; lat = W + 1; end
      4'd13: begin dz = (y == 0); r = dz ? x : x % y;  lat = W + 1; end
      default: begin ill = 1'b1; r = '0; end
    endcase
    f = {dz, ill, r[W-1], v, c};
  endfunction

  // Drive one request, hold in_valid until accepted, then record the expected
  // response. Operands are scrambled right after acceptance.
  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input int hold, output int waits);
    exp_t e;
    bit   xfer;
    @(negedge clk);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    waits    = 0;
    xfer     = 1'b0;
    #4;
    forever begin
      xfer = in_ready;
      @(posedge clk);
      #1;
      if (xfer) break;
      waits++;
      if (waits > 200) begin
        assert_cnt++;
        fail_cnt++;
        $display("[TB] FAIL accept_timeout: request op=%0d not accepted after %0d cycles, expected acceptance", o, waits);
        break;
      end
      #8;
    end
    if (xfer) begin
      model(o, x, y, e.res, e.flg, e.lat);
      e.zf     = (e.res == '0);
      e.t_xfer = cycle - 1;
      e.hold   = hold;
      sb.push_back(e);
      inflight = 1'b1;
    end
    in_valid = 1'b0;
    op       = 4'($urandom);
    a        = $urandom;
    b        = $urandom;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h0000_0001;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares each presented result against the scoreboard head,
  // checks in_ready tracks the outstanding request, and applies backpressure.
  initial begin : monitor
    exp_t cur;
    bit   active;
    bit   done_pending;
    int   hold_left;
    active       = 1'b0;
    done_pending = 1'b0;
    hold_left    = 0;
    out_ready    = 1'b0;
    wait (started);
    forever begin
      @(negedge clk);
      if (done_pending) begin
        inflight     = 1'b0;
        done_pending = 1'b0;
        active       = 1'b0;
      end
      checkOutput("in_ready", 64'(in_ready), 64'(!inflight));
      if (out_valid) begin
        if (!active) begin
          if (sb.size() == 0) begin
            assert_cnt++;
            fail_cnt++;
            $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected 0 with no request outstanding (cycle %0d)", cycle);
            out_ready    = 1'b1;
            done_pending = 1'b1;
            continue;
          end
          cur       = sb.pop_front();
          active    = 1'b1;
          hold_left = cur.hold;
          checkOutput("latency", 64'(cycle - cur.t_xfer), 64'(cur.lat));
        end
        checkOutput("result", 64'(result), 64'(cur.res));
        checkOutput("flags", 64'(flags), 64'(cur.flg));
        checkOutput("zero_flag", 64'(zero_flag), 64'(cur.zf));
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready    = 1'b1;
          done_pending = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int waits;
    int nv;
    int budget;
    reset    = 1'b1;
    in_valid = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'(0));
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_result", 64'(result), 64'(0));
    checkOutput("reset_flags", 64'(flags), 64'(0));
    checkOutput("reset_zero", 64'(zero_flag), 64'(1));
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'(1));
    started = 1'b1;

    // Directed cases
    applyStimulus(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, waits);
    checkOutput("first_xfer_waits", 64'(waits), 64'(0));
    applyStimulus(4'd1, 32'd5, 32'd5, 0, waits);
    applyStimulus(4'd1, 32'd0, 32'd1, 1, waits);
    applyStimulus(4'd10, 32'hFFFF_FFFF, 32'd2, 0, waits);
    applyStimulus(4'd11, 32'hFFFF_FFFF, 32'd2, 2, waits);
    applyStimulus(4'd12, 32'd7, 32'd0, 0, waits);
    applyStimulus(4'd13, 32'd7, 32'd0, 0, waits);
    applyStimulus(4'd12, 32'd100, 32'd7, 0, waits);
    applyStimulus(4'd13, 32'd100, 32'd7, 1, waits);
    applyStimulus(4'd8, 32'h8000_0000, 32'd4, 5, waits);
    applyStimulus(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 0, waits);
    applyStimulus(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, waits);

    // Reset pulse in the middle of a divide abandons it
    applyStimulus(4'd12, 32'd1000, 32'd3, 0, waits);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset_in_ready", 64'(in_ready), 64'(0));
    checkOutput("midreset_result", 64'(result), 64'(0));
    checkOutput("midreset_flags", 64'(flags), 64'(0));
    checkOutput("midreset_zero", 64'(zero_flag), 64'(1));
    sb.delete();
    inflight = 1'b0;
    #1;
    reset = 1'b0;
    nv = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    checkOutput("no_valid_after_reset", 64'(nv), 64'(0));
    applyStimulus(4'd0, 32'd2, 32'd3, 1, waits);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = pick_operand();
      rb = pick_operand();
      applyStimulus(ro, ra, rb, $urandom_range(0, 3), waits);
    end

    budget = 0;
    while ((sb.size() != 0 || inflight) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("drain_complete", 64'(budget < 200), 64'(1));

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
